// File: rtl/aes_round_core.sv
// AES round engine: one full encryption or inverse round, including AddRoundKey, on a
// 128-bit state. The S-box stage is iterative and substitutes SBOX_PAR bytes per cycle.
module aes_round_core #(
  parameter int SBOX_PAR = 16,
  parameter bit KEY_ADD  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         dec_i,
  input  logic         bypass_mc_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] state_o
);
  localparam int N     = 16 / SBOX_PAR;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(SBOX_PAR == 1 || SBOX_PAR == 2 || SBOX_PAR == 4 || SBOX_PAR == 8 || SBOX_PAR == 16))
  begin : g_bad_par
    $error("aes_round_core: SBOX_PAR must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // One shared inverter serves both directions; only the affine step differs.
  function automatic logic [7:0] sub_byte(input logic [7:0] a, input logic inv);
    logic [7:0] pre, x;
    pre = inv ? (rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05) : a;
    x   = gf_inv(pre);
    return inv ? x : (x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [1:0]   sc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = 2'(inv ? (c - r) : (c + r));
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*int'(sc)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [1:0]   k;
    logic [127:0] o;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          k   = 2'(j - r);
          acc = acc ^ gf_mul(coef[k], s[127-8*(4*c+j) -: 8]);
        end
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       w_reg [16];
  logic [127:0]     key_reg;
  logic [127:0]     result_reg;
  logic             dec_reg;
  logic             byp_reg;

  logic             accept;
  logic             last_sub;
  logic [127:0]     key_eff;
  logic [127:0]     dec_pre;
  logic [127:0]     w_load;
  logic [7:0]       w_load_b [16];
  logic [7:0]       w_sub [16];
  logic [127:0]     w_sub_flat;
  logic [3:0]       base;
  logic [7:0]       sub_out [SBOX_PAR];
  logic [127:0]     enc_sr;
  logic [127:0]     enc_res;
  logic [127:0]     round_res;

  assign in_ready_o  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready_i);
  assign out_valid_o = (state_reg == S_DONE);
  assign state_o     = result_reg;
  assign accept      = in_valid_i && in_ready_o;
  assign last_sub    = (cnt_reg == CNT_W'(N - 1));

  // The inverse round front-loads ARK/IMC/ISR so only the S-box pass is iterative.
  assign key_eff = KEY_ADD ? key_i : '0;
  assign dec_pre = state_i ^ key_eff;
  assign w_load  = dec_i ? shift_rows(bypass_mc_i ? dec_pre : mix_cols(dec_pre, 1'b1), 1'b1)
                         : state_i;

  assign base = 4'(cnt_reg * SBOX_PAR);

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign w_load_b[gi]                = w_load[8*(15-gi) +: 8];
    assign w_sub_flat[8*(15-gi) +: 8]  = w_sub[gi];
  end

  for (genvar gi = 0; gi < SBOX_PAR; gi++) begin : g_sbox
    assign sub_out[gi] = sub_byte(w_reg[base + 4'(gi)], dec_reg);
  end

  always_comb begin
    w_sub = w_reg;
    for (int i = 0; i < SBOX_PAR; i++) begin
      w_sub[base + 4'(i)] = sub_out[i];
    end
  end

  assign enc_sr    = shift_rows(w_sub_flat, 1'b0);
  assign enc_res   = (byp_reg ? enc_sr : mix_cols(enc_sr, 1'b0)) ^ key_reg;
  assign round_res = dec_reg ? w_sub_flat : enc_res;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_SUB;
      S_SUB:   if (last_sub) state_next = S_DONE;
      S_DONE:  if (out_ready_i) state_next = accept ? S_SUB : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      key_reg    <= '0;
      result_reg <= '0;
      dec_reg    <= 1'b0;
      byp_reg    <= 1'b0;
      for (int i = 0; i < 16; i++) w_reg[i] <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        w_reg   <= w_load_b;
        key_reg <= key_eff;
        dec_reg <= dec_i;
        byp_reg <= bypass_mc_i;
        cnt_reg <= '0;
      end else if (state_reg == S_SUB) begin
        w_reg   <= w_sub;
        cnt_reg <= last_sub ? '0 : cnt_reg + 1'b1;
        if (last_sub) result_reg <= round_res;
      end
    end
  end

endmodule
